// File: rtl/ws2812_pkg.sv
// Shared types and default timing for the WS2812 transmit sequencer.
// Default timing assumes a 50 MHz clock.
package ws2812_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        BIT   = 2'd2,
        RESET = 2'd3
    } state_e;

    localparam int unsigned DEF_T0H          = 20;    // 0.4 us high for a '0'
    localparam int unsigned DEF_T1H          = 40;    // 0.8 us high for a '1'
    localparam int unsigned DEF_T_BIT        = 63;    // 1.26 us per bit
    localparam int unsigned DEF_T_RESET      = 2500;  // 50 us latch gap
    localparam int unsigned DEF_N_LEDS       = 8;
    localparam int unsigned DEF_BITS_PER_LED = 24;

    localparam int unsigned BIT_IDX_W = 5;

    // Width able to index n distinct values; never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned DEF_LED_W = idx_w(DEF_N_LEDS);

endpackage

// File: rtl/ws2812_tx_sequencer_if.sv
// Control/strobe bundle between the refresh logic, the frame datapath and
// the sequencer. The sequencer side is the slave modport.
interface ws2812_tx_sequencer_if #(
    parameter int unsigned LED_W = 3
) ();
    logic             start;
    logic             auto_repeat;
    logic             bit_in;
    logic             load_rqst;
    logic             new_bit_rqst;
    logic             new_frame_rqst;
    logic             dout;
    logic             busy;
    logic             done;
    logic [LED_W-1:0] led_idx;
    logic [4:0]       bit_idx;

    modport master (
        output start, auto_repeat, bit_in,
        input  load_rqst, new_bit_rqst, new_frame_rqst, dout, busy, done,
               led_idx, bit_idx
    );

    modport slave (
        input  start, auto_repeat, bit_in,
        output load_rqst, new_bit_rqst, new_frame_rqst, dout, busy, done,
               led_idx, bit_idx
    );
endinterface

// File: rtl/ws2812_tx_sequencer_cnt.sv
// Loadable down-counter that saturates at zero and flags terminal count.
module ws2812_tx_sequencer_cnt
    import ws2812_pkg::*;
#(
    parameter int unsigned CNT_MAX = DEF_T_RESET,
    localparam int unsigned W      = idx_w(CNT_MAX)
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_o
);
    logic [W-1:0] cnt_q;

    // Load has priority; otherwise count down and hold at zero.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == '0);

endmodule

// File: rtl/ws2812_tx_sequencer.sv
// WS2812 transmit sequencer: paces load/shift/advance strobes to the frame
// datapath and produces the NRZ pulse-width data line plus the latch gap.
module ws2812_tx_sequencer
    import ws2812_pkg::*;
#(
    parameter int unsigned T0H          = DEF_T0H,
    parameter int unsigned T1H          = DEF_T1H,
    parameter int unsigned T_BIT        = DEF_T_BIT,
    parameter int unsigned T_RESET      = DEF_T_RESET,
    parameter int unsigned N_LEDS       = DEF_N_LEDS,
    parameter int unsigned BITS_PER_LED = DEF_BITS_PER_LED
) (
    input  logic                 clk,
    input  logic                 rstn,
    ws2812_tx_sequencer_if.slave bus
);
    localparam int unsigned CNT_MAX = (T_BIT > T_RESET) ? T_BIT : T_RESET;
    localparam int unsigned CW      = idx_w(CNT_MAX);
    localparam int unsigned LED_W   = idx_w(N_LEDS);

    // The counter runs down, so "elapsed" time within a bit is
    // T_BIT-1-cnt; the line is high while cnt >= T_BIT-thigh.
    localparam logic [CW-1:0] BIT_LAST = CW'(T_BIT - 1);
    localparam logic [CW-1:0] RST_LAST = CW'(T_RESET - 1);
    localparam logic [CW-1:0] LO0      = CW'(T_BIT - T0H);
    localparam logic [CW-1:0] LO1      = CW'(T_BIT - T1H);
    localparam logic [CW-1:0] ONE      = CW'(1);

    // Strobes are registered one cycle ahead (on cnt==1), which needs at
    // least two cycles per bit and per latch gap.
    if (!(T0H >= 1 && T0H < T1H && T1H < T_BIT)) begin : g_bad_timing
        $error("ws2812_tx_sequencer: need 1 <= T0H < T1H < T_BIT");
    end
    if (T_RESET < 2 || N_LEDS < 1 || BITS_PER_LED < 1 || BITS_PER_LED > 32) begin : g_bad_size
        $error("ws2812_tx_sequencer: bad T_RESET/N_LEDS/BITS_PER_LED");
    end

    state_e                 state_q;
    logic [LED_W-1:0]       led_q;
    logic [BIT_IDX_W-1:0]   bidx_q;
    logic                   load_q, nbit_q, nfrm_q, busy_q, done_q;
    logic                   dout_q, dout_d;
    logic                   bit_q, bit_d;
    logic                   bit_cur;
    logic [CW-1:0]          cnt;
    logic                   cnt_tc;
    logic                   cnt_ld_d;
    logic [CW-1:0]          cnt_val_d;
    logic                   last_bit, last_led;

    assign last_bit = (bidx_q == BIT_IDX_W'(BITS_PER_LED - 1));
    assign last_led = (led_q == LED_W'(N_LEDS - 1));

    ws2812_tx_sequencer_cnt #(
        .CNT_MAX (CNT_MAX)
    ) u_cnt (
        .clk    (clk),
        .rstn   (rstn),
        .load_i (cnt_ld_d),
        .val_i  (cnt_val_d),
        .cnt_o  (cnt),
        .tc_o   (cnt_tc)
    );

    // Counter reload: a full bit on entering/continuing BIT, the latch gap
    // when the final bit of the final LED completes.
    always_comb begin
        cnt_ld_d  = 1'b0;
        cnt_val_d = BIT_LAST;
        case (state_q)
            LOAD: cnt_ld_d = 1'b1;
            BIT: begin
                if (cnt_tc && !last_bit) begin
                    cnt_ld_d = 1'b1;
                end else if (cnt_tc && last_led) begin
                    cnt_ld_d  = 1'b1;
                    cnt_val_d = RST_LAST;
                end
            end
            default: ;
        endcase
    end

    // The first cycle of a bit uses bit_in directly; later cycles use the
    // captured copy since the shift register may move on.
    always_comb begin
        bit_cur = (cnt == BIT_LAST) ? bus.bit_in : bit_q;
        bit_d   = (state_q == BIT && cnt == BIT_LAST) ? bus.bit_in : bit_q;
        dout_d  = (state_q == BIT) && (cnt >= (bit_cur ? LO1 : LO0));
    end

    // Line driver and captured bit.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dout_q <= 1'b0;
            bit_q  <= 1'b0;
        end else begin
            dout_q <= dout_d;
            bit_q  <= bit_d;
        end
    end

    // Sequencer FSM; each strobe is set on entry to the cycle it covers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            led_q   <= '0;
            bidx_q  <= '0;
            load_q  <= 1'b0;
            nbit_q  <= 1'b0;
            nfrm_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q <= LOAD;
                        load_q  <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                LOAD: begin
                    state_q <= BIT;
                    load_q  <= 1'b0;
                end
                BIT: begin
                    if (cnt_tc) begin
                        nbit_q <= 1'b0;
                        nfrm_q <= 1'b0;
                        if (!last_bit) begin
                            bidx_q <= bidx_q + BIT_IDX_W'(1);
                        end else begin
                            bidx_q <= '0;
                            if (!last_led) begin
                                led_q   <= led_q + LED_W'(1);
                                state_q <= LOAD;
                                load_q  <= 1'b1;
                            end else begin
                                led_q   <= '0;
                                state_q <= RESET;
                            end
                        end
                    end else if (cnt == ONE) begin
                        if (!last_bit) nbit_q <= 1'b1;
                        else           nfrm_q <= 1'b1;
                    end
                end
                RESET: begin
                    if (cnt_tc) begin
                        done_q <= 1'b0;
                        if (bus.auto_repeat) begin
                            state_q <= LOAD;
                            load_q  <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else if (cnt == ONE) begin
                        done_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.load_rqst      = load_q;
    assign bus.new_bit_rqst   = nbit_q;
    assign bus.new_frame_rqst = nfrm_q;
    assign bus.dout           = dout_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.led_idx        = led_q;
    assign bus.bit_idx        = bidx_q;

endmodule

// File: tb/tb_ws2812_tx_sequencer.sv
// Directed bench: small-timing instance with a model shift register, plus a
// default-timing instance fed all-ones frames.
module tb_ws2812_tx_sequencer;

    logic clk;
    logic rstn;

    int n_chk  = 0;
    int n_fail = 0;

    ws2812_tx_sequencer_if #(.LED_W(1)) ifa ();
    ws2812_tx_sequencer_if #(.LED_W(3)) ifb ();

    ws2812_tx_sequencer #(
        .T0H(2), .T1H(4), .T_BIT(6), .T_RESET(10), .N_LEDS(2), .BITS_PER_LED(3)
    ) dut_a (
        .clk  (clk),
        .rstn (rstn),
        .bus  (ifa.slave)
    );

    ws2812_tx_sequencer dut_b (
        .clk  (clk),
        .rstn (rstn),
        .bus  (ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame datapath model for instance A: frame 0 = 101, frame 1 = 010, MSB first.
    logic [2:0] sr;
    logic       fc;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sr <= 3'b000;
            fc <= 1'b0;
        end else begin
            if (ifa.load_rqst)         sr <= fc ? 3'b010 : 3'b101;
            else if (ifa.new_bit_rqst) sr <= {sr[1:0], 1'b0};
            if (ifa.new_frame_rqst)    fc <= ~fc;
        end
    end
    assign ifa.bit_in = sr[2];
    assign ifb.bit_in = 1'b1;

    // Expected per-cycle vectors for one refresh of A (bit n = cycle n, LOAD at 1).
    localparam logic [63:0] E_DOUT = 64'h0000_000C_F0C7_8678;
    localparam logic [63:0] E_LOAD = 64'h0000_0000_0010_0002;
    localparam logic [63:0] E_NBIT = 64'h0000_0001_0400_2080;
    localparam logic [63:0] E_NFRM = 64'h0000_0040_0008_0000;
    localparam logic [63:0] E_DONE = 64'h0001_0000_0000_0000;
    localparam logic [63:0] E_BUSY = 64'h0001_FFFF_FFFF_FFFE;
    localparam logic [63:0] M_WIN  = 64'h0001_FFFF_FFFF_FFFE;

    logic [191:0] vd, vl, vb, vf, vdn, vbz;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] outs_a();
        return {52'd0, ifa.dout, ifa.busy, ifa.load_rqst, ifa.new_bit_rqst,
                ifa.new_frame_rqst, ifa.done, ifa.led_idx, ifa.bit_idx};
    endfunction

    function automatic logic [63:0] outs_b();
        return {50'd0, ifb.dout, ifb.busy, ifb.load_rqst, ifb.new_bit_rqst,
                ifb.new_frame_rqst, ifb.done, ifb.led_idx, ifb.bit_idx};
    endfunction

    // Record A's outputs for cycles 1..n; optional start pulses and auto_repeat drop.
    task automatic cap_a(input int n, input int s0, input int s1, input int ar_off);
        vd = '0; vl = '0; vb = '0; vf = '0; vdn = '0; vbz = '0;
        for (int c = 1; c <= n; c++) begin
            vd[c]  = ifa.dout;
            vl[c]  = ifa.load_rqst;
            vb[c]  = ifa.new_bit_rqst;
            vf[c]  = ifa.new_frame_rqst;
            vdn[c] = ifa.done;
            vbz[c] = ifa.busy;
            ifa.start = (c == s0) || (c == s1);
            if (c == ar_off) ifa.auto_repeat = 1'b0;
            tick();
        end
        ifa.start = 1'b0;
    endtask

    initial begin
        int done_c, first_rise, first_fall, second_rise;
        int high_total, last_high, run, min_run, max_run;
        logic prev;

        ifa.start = 1'b0; ifa.auto_repeat = 1'b0;
        ifb.start = 1'b0; ifb.auto_repeat = 1'b0;
        rstn = 1'b0;
        tick();
        chk("reset_a", outs_a(), 64'd0);
        chk("reset_b", outs_b(), 64'd0);
        tick();
        rstn = 1'b1;
        tick();
        chk("idle_a", outs_a(), 64'd0);

        // Single refresh, start pokes during BIT (cycle 10) and RESET (cycle 42).
        ifa.start = 1'b1;
        tick();
        cap_a(63, 10, 42, 0);
        chk("t1_dout",  vd[63:0],  E_DOUT);
        chk("t1_load",  vl[63:0],  E_LOAD);
        chk("t1_nbit",  vb[63:0],  E_NBIT);
        chk("t1_nfrm",  vf[63:0],  E_NFRM);
        chk("t1_done",  vdn[63:0], E_DONE);
        chk("t1_busy",  vbz[63:0], E_BUSY);
        chk("t1_n_nbit", 64'($countones(vb)), 64'd4);
        chk("t1_n_nfrm", 64'($countones(vf)), 64'd2);
        chk("t1_n_load", 64'($countones(vl)), 64'd2);
        chk("t1_n_done", 64'($countones(vdn)), 64'd1);
        chk("t1_excl", 64'($countones((vl & vb) | (vl & vf) | (vb & vf))), 64'd0);

        // Three back-to-back refreshes via auto_repeat, dropped during the third.
        tick();
        ifa.auto_repeat = 1'b1;
        ifa.start = 1'b1;
        tick();
        cap_a(160, 0, 0, 100);
        for (int r = 0; r < 3; r++) begin
            chk($sformatf("ar%0d_dout", r), vd[48*r +: 64] & M_WIN, E_DOUT);
            chk($sformatf("ar%0d_load", r), vl[48*r +: 64] & M_WIN, E_LOAD);
            chk($sformatf("ar%0d_done", r), vdn[48*r +: 64] & M_WIN, E_DONE);
        end
        chk("ar_reload", {62'd0, vl[49], vl[97]}, 64'd3);
        chk("ar_stop", {62'd0, vl[145], vbz[145]}, 64'd0);
        chk("ar_excl", 64'($countones((vl & vb) | (vl & vf) | (vb & vf))), 64'd0);

        // Reset mid second bit, then a clean refresh from bit 0.
        tick();
        ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        repeat (9) tick();
        chk("pre_rst", {62'd0, ifa.dout, ifa.bit_idx[0]}, 64'd3);
        rstn = 1'b0;
        #1;
        chk("mid_rst", outs_a(), 64'd0);
        tick();
        rstn = 1'b1;
        tick();
        ifa.start = 1'b1;
        tick();
        cap_a(50, 0, 0, 0);
        chk("rr_dout", vd[63:0],  E_DOUT);
        chk("rr_load", vl[63:0],  E_LOAD);
        chk("rr_done", vdn[63:0], E_DONE);

        // Default timing, all-ones frames.
        ifb.start = 1'b1;
        tick();
        ifb.start = 1'b0;
        done_c = 0; first_rise = 0; first_fall = 0; second_rise = 0;
        high_total = 0; last_high = 0; run = 0; min_run = 1000; max_run = 0;
        prev = 1'b0;
        for (int c = 1; c <= 15000; c++) begin
            if (ifb.dout) begin
                high_total++;
                last_high = c;
                run++;
                if (!prev) begin
                    if (first_rise == 0)       first_rise = c;
                    else if (second_rise == 0) second_rise = c;
                end
            end else if (prev) begin
                if (first_fall == 0) first_fall = c;
                if (run < min_run) min_run = run;
                if (run > max_run) max_run = run;
                run = 0;
            end
            prev = ifb.dout;
            if (ifb.done) begin
                done_c = c;
                break;
            end
            tick();
        end
        chk("b_done_cycle", 64'(done_c), 64'd14604);
        chk("b_first_rise", 64'(first_rise), 64'd3);
        chk("b_high_w", 64'(first_fall - first_rise), 64'd40);
        chk("b_low_w", 64'(second_rise - first_fall), 64'd23);
        chk("b_min_run", 64'(min_run), 64'd40);
        chk("b_max_run", 64'(max_run), 64'd40);
        chk("b_high_total", 64'(high_total), 64'd7680);
        chk("b_last_high", 64'(last_high), 64'd12082);
        chk("b_busy_done", {63'd0, ifb.busy}, 64'd1);
        tick();
        chk("b_idle", {62'd0, ifb.busy, ifb.load_rqst}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
